// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU responder.
//   - alu_op_t        : 3-bit opcode type
//   - OP_AND..OP_SLT  : opcode encodings
//   - is_legal_op()   : opcode legality; OP_SLT is legal only when the
//                       ALU_SLT_EN macro is defined at compile time.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_AND = 3'b000;
  localparam alu_op_t OP_OR  = 3'b001;
  localparam alu_op_t OP_ADD = 3'b010;
  localparam alu_op_t OP_SUB = 3'b110;
  localparam alu_op_t OP_SLT = 3'b111;

  function automatic logic is_legal_op(alu_op_t op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
`ifdef ALU_SLT_EN
      OP_SLT:                        return 1'b1;
`endif
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
// Ports:
//   a, b  in  W  operands
//   op    in  3  opcode (see alu_pkg)
//   z     out W  result, modulo 2^W; 0 for illegal opcodes
//   ovf   out 1  signed overflow, ADD/SUB only
//   err   out 1  illegal opcode
// Compile-time option: ALU_SLT_EN enables signed set-less-than on op 111;
// without it no SLT logic exists and op 111 reports err.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] z,
  output logic         ovf,
  output logic         err
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic         ovf_add;
  logic         ovf_sub;

  assign sum  = a + b;
  assign diff = a + ~b + ONE;

  // Overflow: operands that can produce an out-of-range result gave a
  // result whose sign disagrees with a.
  assign ovf_add = (a[W-1] == b[W-1]) && (sum[W-1]  != a[W-1]);
  assign ovf_sub = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);

  // NOTE: every output gets a default before the case so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    z   = '0;
    ovf = 1'b0;
    err = !is_legal_op(op);
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_ADD: begin
        z   = sum;
        ovf = ovf_add;
      end
      OP_SUB: begin
        z   = diff;
        ovf = ovf_sub;
      end
`ifdef ALU_SLT_EN
      // Signed less-than: the true sign of (a - b) is the raw sign bit
      // corrected by overflow.
      OP_SLT: z = {{(W-1){1'b0}}, diff[W-1] ^ ovf_sub};
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_resp_unit.sv
// alu_resp_unit: registered, handshaked ALU execute responder.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; req_a, req_b (W), req_op (3)
//   rsp_valid/ready   response handshake
//   rsp_z (W)         result; rsp_zero, rsp_ovf, rsp_err flags
//   ops_done (CNT_W)  wrapping count of accepted responses
// One output register (EMPTY/FULL), 1-cycle latency, 1 op/cycle throughput.
// req_ready passes rsp_ready through combinationally (no skid buffer).
// Compile-time option: ALU_SLT_EN (forwarded to alu_core).
module alu_resp_unit
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_z,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t       state;
  logic         init_q;   // low until the first edge after reset release
  logic [W-1:0] core_z;
  logic         core_ovf;
  logic         core_err;
  logic         req_fire;
  logic         rsp_fire;

  alu_core #(.W(W)) u_core (
    .a   (req_a),
    .b   (req_b),
    .op  (req_op),
    .z   (core_z),
    .ovf (core_ovf),
    .err (core_err)
  );

  assign rsp_valid = (state == FULL);
  assign req_ready = init_q && (!rsp_valid || rsp_ready);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      init_q   <= 1'b0;
      rsp_z    <= '0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_err  <= 1'b0;
      ops_done <= '0;
    end else begin
      init_q <= 1'b1;
      if (rsp_fire) ops_done <= ops_done + CNT_ONE;

      // A request fire in either state loads the register; in FULL that
      // only happens alongside a response fire, so nothing is lost.
      if (req_fire) begin
        state    <= FULL;
        rsp_z    <= core_z;
        rsp_zero <= (core_z == '0);
        rsp_ovf  <= core_ovf;
        rsp_err  <= core_err;
      end else if (rsp_fire) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: doc/alu_resp_unit.md
Name: alu_resp_unit

Overview:
- Registered, handshaked ALU execute responder.
- Accepts {a, b, op} requests from an initiator over a valid/ready channel and returns the result, zero, overflow and error flags on a valid/ready response channel.
- Sits between the instruction-issue logic and writeback. Replaces the bare combinational ALU hookup wherever back-pressure is needed.

Parameters:
- W, 32, operand and result width in bits.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_a  in  W  operand a.
- req_b  in  W  operand b.
- req_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (only with ALU_SLT_EN); all other codes illegal.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_z  out  W  result.
- rsp_zero  out  1  rsp_z == 0.
- rsp_ovf  out  1  signed overflow; ADD/SUB only, else 0.
- rsp_err  out  1  illegal opcode.
- ops_done  out  CNT_W  count of accepted responses.

Behaviour:
- Reset (asynchronous assert, synchronous release): rsp_valid=0, rsp_z=0, rsp_zero=0, rsp_ovf=0, rsp_err=0, ops_done=0. req_ready is 1 after the first clock edge following release.
- Single output register, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Handshake and readiness:
  - req_ready = !rsp_valid || rsp_ready (combinational pass-through of rsp_ready; no skid).
  - A request fires when req_valid && req_ready. A response fires when rsp_valid && rsp_ready.
  - Latency is exactly 1 cycle: a request firing at edge N appears on rsp_* after edge N.
- State transitions:
  - EMPTY, request fires → FULL, result loaded.
  - FULL, response fires, no request → EMPTY.
  - FULL, response and request fire in the same cycle → stays FULL with the new result. No bubble, so throughput is 1 op/cycle.
  - FULL, rsp_ready=0 → hold all rsp_* stable. req_ready=0, and any presented request is not consumed.
- Arithmetic:
  - All operations are modulo 2^W.
  - ADD: ovf = (a[W-1]==b[W-1]) && (z[W-1]!=a[W-1]).
  - SUB: z = a + ~b + 1; ovf = (a[W-1]!=b[W-1]) && (z[W-1]!=a[W-1]).
  - AND/OR: ovf=0.
- Illegal op: z=0, zero=1, ovf=0, err=1. An illegal op still completes and is counted.
- ops_done increments on every response fire and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-transaction: the pending response is discarded and nothing is replayed.
- Request inputs are sampled only on fire. Changes on the request inputs while req_ready=0 are ignored.

Optional Feature:
- Macro: ALU_SLT_EN.
- Defined: op 111 = signed set-less-than. z = {W-1 zeros, (a-b)[W-1] XOR ovf_sub}, ovf=0, err=0.
- Undefined: op 111 is illegal (err=1, z=0). No SLT logic is synthesized.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT;
  - a typedef alu_op_t of 3 bits;
  - a function is_legal_op honouring ALU_SLT_EN.
- One natural sub-module: alu_core, purely combinational, computing (a, b, op) → z, ovf, err.
- alu_resp_unit holds the handshake register, state and counter.

Test Plan:
- Reset then single ADD: a=0x7FFFFFFF, b=0x00000001, op=010, rsp_ready=1 → next cycle rsp_valid=1, z=0x80000000, ovf=1, zero=0, err=0, ops_done=1 after the fire.
- SUB to zero: a=b=0x12345678, op=110 → z=0, zero=1, ovf=0. Then AND 0xF0F0F0F0&0x0FF00FF0 → z=0x00F000F0. Then OR of the same operands → z=0xFFF0FFF0.
- Back-pressure: rsp_ready=0 for 3 cycles after the first result (AND 0xFFFF0000&0x0F0F0F0F=0x0F0F0000) → rsp_z held at 0x0F0F0000, req_ready=0, a second request (OR 1|2) is not consumed. Raise rsp_ready → the OR result z=3 appears the next cycle.
- Streaming: 8 back-to-back requests with rsp_ready=1 → 8 responses on 8 consecutive cycles, in order, ops_done=8.
- Illegal op 011 (and 111 without ALU_SLT_EN) → z=0, zero=1, err=1, counted. With ALU_SLT_EN: a=0xFFFFFFFF, b=1, op=111 → z=1; a=1, b=0xFFFFFFFF → z=0.
- Reset mid-op: assert rst_n=0 while rsp_valid=1 and rsp_ready=0 → rsp_valid, rsp_z and ops_done go to 0 immediately, without waiting for a clock edge.
